prog_launcher: RTL and testbench

//  Host-side initiator of the processor's Reset/Start/Ack run protocol: sequences
//  NUM_PROGS programs back to back and measures each run in clocks. Per program it

---
 rtl/prog_launcher_pkg.sv | 17 +
 rtl/launch_timer.sv | 39 +++
 rtl/prog_launcher.sv | 155 +++++++++++++++
 tb/tb_prog_launcher.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/prog_launcher_pkg.sv
// Shared types and widths for the program launcher.
package prog_launcher_pkg;

  localparam int unsigned CNT_W = 16;
  localparam int unsigned SEL_W = 2;

  typedef enum logic [2:0] {
    IDLE,
    DRST,
    START,
    ARM,
    RUN,
    REC,
    FIN
  } state_t;

endpackage

// File: rtl/launch_timer.sv
// Saturating up-counter with synchronous clear, enable and a compare against
// a limit. nxt_c is the value loaded at the coming edge; hit_c flags that the
// count reaches the limit on this enabled clock.
module launch_timer
  import prog_launcher_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] nxt_c,
  output logic             hit_c
);

  logic [CNT_W-1:0] cnt;

  // Next count: clear wins, otherwise increment and stick at all-ones
  always_comb begin
    nxt_c = cnt;
    if (clr) begin
      nxt_c = '0;
    end else if (en && (cnt != '1)) begin
      nxt_c = cnt + CNT_W'(1);
    end
  end

  assign hit_c = en && !clr && (nxt_c == limit);

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      cnt <= nxt_c;
    end
  end

endmodule

// File: rtl/prog_launcher.sv
// Host-side launcher for the processor Reset/Start/Ack protocol: runs
// NUM_PROGS programs back to back and measures each run in clocks.
// Optional macro PROG_LAUNCH_LOG_EN adds a per-program cycle log with a
// combinational read port (LogIdx/LogCycles).
module prog_launcher
  import prog_launcher_pkg::*;
#(
  parameter int unsigned      NUM_PROGS   = 3,
  parameter int unsigned      START_CYC   = 2,
  parameter logic [CNT_W-1:0] TIMEOUT_MAX = 16'hFFF0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Go,
  input  logic             DutAck,
  output logic             DutReset,
  output logic             DutStart,
  output logic [SEL_W-1:0] ProgSel,
  output logic             Busy,
  output logic             ResValid,
  output logic [CNT_W-1:0] LastCycles,
  output logic             TimedOut,
  output logic             BatchDone
`ifdef PROG_LAUNCH_LOG_EN
  ,
  input  logic [SEL_W-1:0] LogIdx,
  output logic [CNT_W-1:0] LogCycles
`endif
);

  state_t           state;
  state_t           state_n;
  logic             to_c;
  logic             last_c;
  logic [CNT_W-1:0] run_nxt;
  logic             run_hit;
  logic [CNT_W-1:0] start_nxt_unused;
  logic             start_hit;

  assign last_c = (ProgSel == SEL_W'(NUM_PROGS - 1));

  // Run-length counter: counts every ARM/RUN clock, cleared once recorded
  launch_timer u_run_timer (
    .clk   (Clk),
    .rst_n (Reset),
    .clr   (state == REC),
    .en    ((state == ARM) || (state == RUN)),
    .limit (TIMEOUT_MAX),
    .nxt_c (run_nxt),
    .hit_c (run_hit)
  );

  // Start-pulse width counter
  launch_timer u_start_timer (
    .clk   (Clk),
    .rst_n (Reset),
    .clr   (state != START),
    .en    (state == START),
    .limit (CNT_W'(START_CYC)),
    .nxt_c (start_nxt_unused),
    .hit_c (start_hit)
  );

  // State register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic; ARM ignores a stale Ack, a real Ack beats a timeout
  always_comb begin
    state_n = state;
    to_c    = 1'b0;
    unique case (state)
      IDLE:  if (Go) state_n = DRST;
      DRST:  state_n = START;
      START: if (start_hit) state_n = ARM;
      ARM: begin
        if (run_hit) begin
          state_n = REC;
          to_c    = 1'b1;
        end else if (!DutAck) begin
          state_n = RUN;
        end
      end
      RUN: begin
        if (DutAck) begin
          state_n = REC;
        end else if (run_hit) begin
          state_n = REC;
          to_c    = 1'b1;
        end
      end
      REC:     state_n = last_c ? FIN : START;
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Registered outputs decoded from the next state; results load on REC entry
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      DutReset   <= 1'b1;
      DutStart   <= 1'b0;
      Busy       <= 1'b0;
      ResValid   <= 1'b0;
      BatchDone  <= 1'b0;
      TimedOut   <= 1'b0;
      ProgSel    <= '0;
      LastCycles <= '0;
    end else begin
      DutReset  <= (state_n == DRST) || ((state_n == IDLE) && DutReset);
      DutStart  <= (state_n == START);
      Busy      <= (state_n != IDLE);
      ResValid  <= (state_n == REC);
      BatchDone <= (state_n == FIN);
      if ((state == IDLE) && Go) begin
        ProgSel  <= '0;
        TimedOut <= 1'b0;
      end
      if (state_n == REC) begin
        LastCycles <= run_nxt;
        if (to_c) TimedOut <= 1'b1;
      end
      if ((state == REC) && !last_c) begin
        ProgSel <= ProgSel + SEL_W'(1);
      end
    end
  end

`ifdef PROG_LAUNCH_LOG_EN
  // Sized to the full select range so every index is width-clean; only the
  // first NUM_PROGS entries are ever written or read back.
  logic [CNT_W-1:0] log_mem [2**SEL_W];

  // Per-program log, written with the recorded count; cleared only by reset
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      log_mem <= '{default: '0};
    end else if (state_n == REC) begin
      log_mem[ProgSel] <= run_nxt;
    end
  end

  // Combinational read port
  always_comb begin
    LogCycles = '0;
    if (32'(LogIdx) < NUM_PROGS) LogCycles = log_mem[LogIdx];
  end
`endif

endmodule

// File: tb/tb_prog_launcher.sv
// Directed bench for prog_launcher (NUM_PROGS=3, START_CYC=2, TIMEOUT_MAX=20).
module tb_prog_launcher;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        go = 1'b0;
  logic        dut_ack = 1'b0;
  logic        dut_reset;
  logic        dut_start;
  logic [1:0]  prog_sel;
  logic        busy;
  logic        res_valid;
  logic [15:0] last_cycles;
  logic        timed_out;
  logic        batch_done;
`ifdef PROG_LAUNCH_LOG_EN
  logic [1:0]  log_idx = 2'd0;
  logic [15:0] log_cycles;
`endif

  int n_chk = 0;
  int n_pass = 0;
  int rv_cnt = 0;
  int bd_cnt = 0;
  int exp_log[3];

  always #5 clk = ~clk;

  prog_launcher #(
    .NUM_PROGS   (3),
    .START_CYC   (2),
    .TIMEOUT_MAX (16'd20)
  ) dut (
    .Clk        (clk),
    .Reset      (rst_n),
    .Go         (go),
    .DutAck     (dut_ack),
    .DutReset   (dut_reset),
    .DutStart   (dut_start),
    .ProgSel    (prog_sel),
    .Busy       (busy),
    .ResValid   (res_valid),
    .LastCycles (last_cycles),
    .TimedOut   (timed_out),
    .BatchDone  (batch_done)
`ifdef PROG_LAUNCH_LOG_EN
    ,
    .LogIdx     (log_idx),
    .LogCycles  (log_cycles)
`endif
  );

  // Pulse counters
  always @(posedge clk) begin
    if (res_valid) rv_cnt++;
    if (batch_done) bd_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic go_pulse();
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  // Return at the negedge inside the first ARM clock (DutStart just dropped)
  task automatic wait_arm();
    int n = 0;
    while (!dut_start && n < 50) begin @(negedge clk); n++; end
    while (dut_start && n < 50) begin @(negedge clk); n++; end
    check("arm_wait", 32'(n < 50), 32'd1);
  endtask

  // Ack high for hi_pre clocks, low for lo_len, then high; run clocks from ARM
  task automatic run_prog(input int hi_pre, input int lo_len, input int go_at,
                          input int exp_cyc, input logic exp_to, input int exp_sel);
    int k = 1;
    wait_arm();
    while (k < 200) begin
      dut_ack = (k <= hi_pre) ? 1'b1 : ((k <= hi_pre + lo_len) ? 1'b0 : 1'b1);
      go = (k == go_at);
      @(negedge clk);
      if (res_valid) break;
      k++;
    end
    go = 1'b0;
    check("res_valid", 32'(res_valid), 32'd1);
    check("last_cycles", 32'(last_cycles), 32'(exp_cyc));
    check("timed_out", 32'(timed_out), 32'(exp_to));
    check("prog_sel", 32'(prog_sel), 32'(exp_sel));
    exp_log[exp_sel] = exp_cyc;
  endtask

  task automatic finish_batch();
    @(negedge clk);
    check("batch_done", 32'(batch_done), 32'd1);
    check("busy_fin", 32'(busy), 32'd1);
    @(negedge clk);
    check("batch_done_1clk", 32'(batch_done), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
    check("dut_reset_idle", 32'(dut_reset), 32'd0);
  endtask

  task automatic check_launch(input logic exp_to_before);
    check("busy_go", 32'(busy), 32'd1);
    check("dut_reset_drst", 32'(dut_reset), 32'd1);
    check("sel_go", 32'(prog_sel), 32'd0);
    check("to_cleared", 32'(timed_out), 32'(exp_to_before));
  endtask

  initial begin
    int rv0;
    int bd0;
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_dut_reset", 32'(dut_reset), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_start", 32'(dut_start), 32'd0);
    check("rst_rv", 32'(res_valid), 32'd0);
    check("rst_bd", 32'(batch_done), 32'd0);
    check("rst_to", 32'(timed_out), 32'd0);
    check("rst_cycles", 32'(last_cycles), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_dut_reset", 32'(dut_reset), 32'd1);

    // 1: plain batch, 10 low clocks then Ack -> 11 each
    go_pulse();
    check_launch(1'b0);
    @(negedge clk);
    check("drst_1clk", 32'(dut_reset), 32'd0);
    for (int i = 0; i < 3; i++) run_prog(0, 10, 0, 11, 1'b0, i);
    finish_batch();
    check("rv_count_b1", 32'(rv_cnt), 32'd3);
    check("bd_count_b1", 32'(bd_cnt), 32'd1);

    // 2: stale Ack high at launch is not accepted
    go_pulse();
    check_launch(1'b0);
    run_prog(3, 5, 0, 9, 1'b0, 0);
    run_prog(0, 10, 0, 11, 1'b0, 1);
    run_prog(3, 5, 0, 9, 1'b0, 2);
    finish_batch();

    // 3: timeout on prog 0, sticky through the batch
    go_pulse();
    run_prog(0, 1000, 0, 20, 1'b1, 0);
    run_prog(0, 4, 0, 5, 1'b1, 1);
    run_prog(0, 4, 0, 5, 1'b1, 2);
    finish_batch();

    // 4: reset during RUN of prog 1 aborts silently; restart from prog 0
    go_pulse();
    check_launch(1'b0);
    run_prog(0, 6, 0, 7, 1'b0, 0);
    wait_arm();
    dut_ack = 1'b0;
    repeat (4) @(negedge clk);
    rv0 = rv_cnt;
    bd0 = bd_cnt;
    rst_n = 1'b0;
    #1;
    check("abort_dut_reset", 32'(dut_reset), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_start", 32'(dut_start), 32'd0);
    repeat (3) @(negedge clk);
    check("abort_no_rv", 32'(rv_cnt), 32'(rv0));
    check("abort_no_bd", 32'(bd_cnt), 32'(bd0));
    rst_n = 1'b1;
    @(negedge clk);
    go_pulse();
    check_launch(1'b0);
    for (int i = 0; i < 3; i++) run_prog(0, 2, 0, 3, 1'b0, i);
    finish_batch();

    // 5: Go while busy ignored; Ack coinciding with timeout wins
    go_pulse();
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    check("busy_go_no_drst", 32'(dut_reset), 32'd0);
    check("busy_go_start", 32'(dut_start), 32'd1);
    run_prog(0, 19, 5, 20, 1'b0, 0);
    run_prog(0, 19, 0, 20, 1'b0, 1);
    run_prog(0, 7, 0, 8, 1'b0, 2);
    finish_batch();
    @(negedge clk);
    check("rv_count_all", 32'(rv_cnt), 32'd16);
    check("bd_count_all", 32'(bd_cnt), 32'd5);

`ifdef PROG_LAUNCH_LOG_EN
    // 6: log read-back of the last batch
    for (int i = 0; i < 3; i++) begin
      log_idx = 2'(i);
      #1;
      check("log_cycles", 32'(log_cycles), 32'(exp_log[i]));
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
